// File: rtl/isa_pkg.sv
// ISA constants shared by the ID stage: opcodes, instruction field positions,
// ID/EX bundle widths and small decode helpers.
package isa_pkg;

    localparam int OP_W   = 6;
    localparam int IMM_W  = 16;
    localparam int OP_LSB = 26;
    localparam int RA_LSB = 21;
    localparam int RB_LSB = 16;
    localparam int RC_LSB = 11;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_NOP = 6'h00;
    localparam opcode_t OP_AND = 6'h01;
    localparam opcode_t OP_OR  = 6'h02;
    localparam opcode_t OP_XOR = 6'h03;
    localparam opcode_t OP_ADD = 6'h04;
    localparam opcode_t OP_SUB = 6'h05;
    localparam opcode_t OP_SHL = 6'h06;
    localparam opcode_t OP_SHR = 6'h07;
    localparam opcode_t OP_BE  = 6'h08;
    localparam opcode_t OP_BNE = 6'h09;
    localparam opcode_t OP_BR  = 6'h0a;
    localparam opcode_t OP_LDW = 6'h0c;
    localparam opcode_t OP_STW = 6'h0d;

    function automatic logic is_alu(input opcode_t op);
        return op inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SHL, OP_SHR};
    endfunction

    // rb is a true source only for these; LDW uses rb as its destination.
    function automatic logic reads_rb(input opcode_t op);
        return is_alu(op) || (op inside {OP_STW, OP_BE, OP_BNE});
    endfunction

endpackage

// File: rtl/id_issue_reg_if.sv
// IF/ID boundary: the IF/ID register contents flowing in, and the redirect
// and stall controls flowing back to the IF register.
interface id_issue_reg_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_insn;
    logic              if_en;
    logic              br_taken;
    logic [ADDR_W-1:0] br_addr;
    logic              ld_hazard;

    modport master (
        output if_pc, if_insn, if_en,
        input  br_taken, br_addr, ld_hazard
    );

    modport slave (
        input  if_pc, if_insn, if_en,
        output br_taken, br_addr, ld_hazard
    );
endinterface

// File: rtl/id_fwd_mux.sv
// Operand forwarding for one GPR source: EX result beats MEM result beats the
// register file. r0 is forwarded like any other register.
module id_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] gpr_data,
    input  logic              ex_en,
    input  logic [REG_AW-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_en,
    input  logic [REG_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] data
);
    always_comb begin
        if (ex_en && (ex_addr == src))
            data = ex_data;
        else if (mem_en && (mem_addr == src))
            data = mem_data;
        else
            data = gpr_data;
    end
endmodule

// File: rtl/id_issue_reg.sv
// ID stage: decode, operand forwarding, branch resolution, load-use hazard
// detection, and the ID/EX pipeline register.
module id_issue_reg
    import isa_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    id_issue_reg_if.slave     ifid,
    input  logic              stall,
    input  logic              flush,
    output logic [REG_AW-1:0] gpr_rd_addr_0,
    output logic [REG_AW-1:0] gpr_rd_addr_1,
    input  logic [DATA_W-1:0] gpr_rd_data_0,
    input  logic [DATA_W-1:0] gpr_rd_data_1,
    input  logic              ex_fwd_en,
    input  logic [REG_AW-1:0] ex_fwd_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              mem_fwd_en,
    input  logic [REG_AW-1:0] mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_en,
    output logic [OP_W-1:0]   id_op,
    output logic [REG_AW-1:0] id_dst_addr,
    output logic              id_gpr_we,
    output logic              id_mem_load,
    output logic [DATA_W-1:0] id_opr_0,
    output logic [DATA_W-1:0] id_opr_1,
    output logic [DATA_W-1:0] id_imm,
    output logic [CNT_W-1:0]  hz_cnt
);

    opcode_t           op;
    logic [REG_AW-1:0] ra, rb, rc;
    logic [DATA_W-1:0] imm_sext;
    logic [ADDR_W-1:0] br_off, br_cond_tgt;

    assign op       = ifid.if_insn[OP_LSB +: OP_W];
    assign ra       = ifid.if_insn[RA_LSB +: REG_AW];
    assign rb       = ifid.if_insn[RB_LSB +: REG_AW];
    assign rc       = ifid.if_insn[RC_LSB +: REG_AW];
    assign imm_sext = {{(DATA_W-IMM_W){ifid.if_insn[IMM_W-1]}}, ifid.if_insn[IMM_W-1:0]};
    assign br_off   = {{(ADDR_W-IMM_W){ifid.if_insn[IMM_W-1]}}, ifid.if_insn[IMM_W-1:0]};
    // Natural ADDR_W-bit add: the target wraps around the word-address space.
    assign br_cond_tgt = ifid.if_pc + br_off;

    assign gpr_rd_addr_0 = ra;
    assign gpr_rd_addr_1 = rb;

    logic [1:0][REG_AW-1:0] src;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [1:0][DATA_W-1:0] opr;

    assign src     = {rb, ra};
    assign rd_data = {gpr_rd_data_1, gpr_rd_data_0};

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        id_fwd_mux #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_fwd (
            .src      (src[i]),
            .gpr_data (rd_data[i]),
            .ex_en    (ex_fwd_en),
            .ex_addr  (ex_fwd_addr),
            .ex_data  (ex_fwd_data),
            .mem_en   (mem_fwd_en),
            .mem_addr (mem_fwd_addr),
            .mem_data (mem_fwd_data),
            .data     (opr[i])
        );
    end

    opcode_t           dec_op;
    logic [REG_AW-1:0] dec_dst;
    logic              dec_we, dec_ld;

    always_comb begin
        dec_op  = OP_NOP;
        dec_dst = '0;
        dec_we  = 1'b0;
        dec_ld  = 1'b0;
        case (op)
            OP_LDW: begin
                dec_op  = OP_LDW;
                dec_dst = rb;
                dec_we  = 1'b1;
                dec_ld  = 1'b1;
            end
            OP_STW, OP_BE, OP_BNE, OP_BR: dec_op = op;
            default: begin
                if (is_alu(op)) begin
                    dec_op  = op;
                    dec_dst = rc;
                    dec_we  = 1'b1;
                end
            end
        endcase
    end

    logic hazard;

    assign hazard = ifid.if_en && id_en && id_mem_load &&
                    ((id_dst_addr == ra) || (reads_rb(op) && (id_dst_addr == rb)));
    assign ifid.ld_hazard = hazard;

    logic              br_taken_c;
    logic [ADDR_W-1:0] br_addr_c;

    // A hazarded branch would compare stale operands, so it resolves only
    // once the load result can be forwarded.
    always_comb begin
        br_taken_c = 1'b0;
        br_addr_c  = ifid.if_pc;
        if (ifid.if_en && !hazard) begin
            case (op)
                OP_BE: begin
                    if (opr[0] == opr[1]) begin
                        br_taken_c = 1'b1;
                        br_addr_c  = br_cond_tgt;
                    end
                end
                OP_BNE: begin
                    if (opr[0] != opr[1]) begin
                        br_taken_c = 1'b1;
                        br_addr_c  = br_cond_tgt;
                    end
                end
                OP_BR: begin
                    br_taken_c = 1'b1;
                    br_addr_c  = opr[0][ADDR_W+1:2];
                end
                default: ;
            endcase
        end
    end

    assign ifid.br_taken = br_taken_c;
    assign ifid.br_addr  = br_addr_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_pc       <= '0;
            id_en       <= 1'b0;
            id_op       <= OP_NOP;
            id_dst_addr <= '0;
            id_gpr_we   <= 1'b0;
            id_mem_load <= 1'b0;
            id_opr_0    <= '0;
            id_opr_1    <= '0;
            id_imm      <= '0;
            hz_cnt      <= '0;
        end else if (!stall) begin
            // Payload always loads; only the valid/side-effect bits decide
            // whether the entry is a bubble.
            id_pc       <= ifid.if_pc;
            id_op       <= dec_op;
            id_dst_addr <= dec_dst;
            id_opr_0    <= opr[0];
            id_opr_1    <= opr[1];
            id_imm      <= imm_sext;
            if (flush || hazard) begin
                id_en       <= 1'b0;
                id_gpr_we   <= 1'b0;
                id_mem_load <= 1'b0;
                if (!flush && (hz_cnt != '1))
                    hz_cnt <= hz_cnt + CNT_W'(1);
            end else begin
                id_en       <= ifid.if_en;
                id_gpr_we   <= dec_we && ifid.if_en;
                id_mem_load <= dec_ld && ifid.if_en;
            end
        end
    end

endmodule

// File: tb/tb_id_issue_reg.sv
// Bench for id_issue_reg: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural model.
module tb_id_issue_reg;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 8;

    localparam logic [5:0] NOP = 6'h00, ADD = 6'h04, SUB = 6'h05, BE = 6'h08,
                           BNE = 6'h09, BR = 6'h0a, LDW = 6'h0c, STW = 6'h0d;
    localparam logic [5:0] POOL [10] = '{6'h00, 6'h04, 6'h05, 6'h01, 6'h0c,
                                         6'h0d, 6'h08, 6'h09, 6'h0a, 6'h3f};

    logic          clk = 1'b0;
    logic          reset, stall, flush;
    logic [RW-1:0] gpr_rd_addr_0, gpr_rd_addr_1;
    logic [DW-1:0] gpr_rd_data_0, gpr_rd_data_1;
    logic          ex_fwd_en, mem_fwd_en;
    logic [RW-1:0] ex_fwd_addr, mem_fwd_addr;
    logic [DW-1:0] ex_fwd_data, mem_fwd_data;
    logic [AW-1:0] id_pc;
    logic          id_en, id_gpr_we, id_mem_load;
    logic [5:0]    id_op;
    logic [RW-1:0] id_dst_addr;
    logic [DW-1:0] id_opr_0, id_opr_1, id_imm;
    logic [CW-1:0] hz_cnt;

    always #5 clk = ~clk;

    id_issue_reg_if #(.ADDR_W(AW), .DATA_W(DW)) ifid ();

    id_issue_reg #(.ADDR_W(AW), .DATA_W(DW), .REG_AW(RW), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .ifid          (ifid),
        .stall         (stall),
        .flush         (flush),
        .gpr_rd_addr_0 (gpr_rd_addr_0),
        .gpr_rd_addr_1 (gpr_rd_addr_1),
        .gpr_rd_data_0 (gpr_rd_data_0),
        .gpr_rd_data_1 (gpr_rd_data_1),
        .ex_fwd_en     (ex_fwd_en),
        .ex_fwd_addr   (ex_fwd_addr),
        .ex_fwd_data   (ex_fwd_data),
        .mem_fwd_en    (mem_fwd_en),
        .mem_fwd_addr  (mem_fwd_addr),
        .mem_fwd_data  (mem_fwd_data),
        .id_pc         (id_pc),
        .id_en         (id_en),
        .id_op         (id_op),
        .id_dst_addr   (id_dst_addr),
        .id_gpr_we     (id_gpr_we),
        .id_mem_load   (id_mem_load),
        .id_opr_0      (id_opr_0),
        .id_opr_1      (id_opr_1),
        .id_imm        (id_imm),
        .hz_cnt        (hz_cnt)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input logic [AW-1:0] pc, input logic [DW-1:0] insn, input logic en);
        ifid.if_pc   = pc;
        ifid.if_insn = insn;
        ifid.if_en   = en;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] lo);
        return {op, a, b, lo};
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_en, m_we, m_ld, m_fv;
    logic [4:0]  m_dst;
    logic [29:0] m_pc;
    logic [5:0]  m_op;
    logic [31:0] m_o0, m_o1, m_imm;
    int          m_hz;

    function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] g);
        if (ex_fwd_en && ex_fwd_addr == s) return ex_fwd_data;
        if (mem_fwd_en && mem_fwd_addr == s) return mem_fwd_data;
        return g;
    endfunction

    function automatic bit is_alu_op(input logic [5:0] op);
        return op inside {[6'h01:6'h07]};
    endfunction

    task automatic model_eval(output bit t, output logic [29:0] a, output bit hz,
                              output logic [31:0] o0, output logic [31:0] o1);
        logic [5:0] op;
        logic [4:0] ra, rb;
        bit         uses_rb;
        longint     simm, tgt;
        op = ifid.if_insn[31:26];
        ra = ifid.if_insn[25:21];
        rb = ifid.if_insn[20:16];
        o0 = fwd(ra, gpr_rd_data_0);
        o1 = fwd(rb, gpr_rd_data_1);
        uses_rb = is_alu_op(op) || op == STW || op == BE || op == BNE;
        hz = ifid.if_en && m_en && m_ld && (m_dst == ra || (uses_rb && m_dst == rb));
        simm = longint'(ifid.if_insn[15:0]);
        if (simm >= 32768) simm = simm - 65536;
        tgt = (longint'(ifid.if_pc) + simm + (longint'(1) << 30)) % (longint'(1) << 30);
        t = ifid.if_en && !hz && ((op == BE && o0 == o1) || (op == BNE && o0 != o1) || op == BR);
        if (!t) a = ifid.if_pc;
        else if (op == BR) a = 30'(o0 / 4);
        else a = 30'(tgt);
    endtask

    task automatic model_reset();
        m_en = 0; m_we = 0; m_ld = 0; m_fv = 1; m_dst = 0; m_pc = 0;
        m_op = NOP; m_o0 = 0; m_o1 = 0; m_imm = 0; m_hz = 0;
    endtask

    task automatic model_update(input bit hz, input logic [31:0] o0, input logic [31:0] o1);
        logic [5:0] op;
        bit         alu, known;
        op    = ifid.if_insn[31:26];
        alu   = is_alu_op(op);
        known = alu || op inside {LDW, STW, BE, BNE, BR};
        if (reset) model_reset();
        else if (!stall) begin
            if (flush || hz) begin
                m_en = 0; m_we = 0; m_ld = 0; m_fv = 0;
                if (!flush && m_hz < 255) m_hz++;
            end else begin
                m_en  = ifid.if_en;
                m_we  = ifid.if_en && (op == LDW || alu);
                m_ld  = ifid.if_en && op == LDW;
                m_dst = (op == LDW) ? ifid.if_insn[20:16] : alu ? ifid.if_insn[15:11] : 5'd0;
                m_op  = known ? op : NOP;
                m_pc  = ifid.if_pc;
                m_o0  = o0;
                m_o1  = o1;
                m_imm = 32'(signed'(ifid.if_insn[15:0]));
                m_fv  = 1;
            end
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [29:0] pc;
        logic [31:0] insn, g0, g1;
        logic        ex_en;
        logic [4:0]  ex_a;
        logic [31:0] ex_d;
        logic        mem_en;
        logic [4:0]  mem_a;
        logic [31:0] mem_d;
        logic        taken;
        logic [29:0] addr;
        logic [31:0] o0, o1, imm;
        logic [5:0]  op;
        logic        we, ld;
        logic [4:0]  dst;
    } vec_t;

    vec_t        tbl [11];
    bit          e_t, e_h;
    logic [29:0] e_a;
    logic [31:0] e_o0, e_o1;
    int          n;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1; stall = 0; flush = 0;
        drive('0, '0, 1'b0);
        gpr_rd_data_0 = 0; gpr_rd_data_1 = 0;
        ex_fwd_en = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
        mem_fwd_en = 0; mem_fwd_addr = 0; mem_fwd_data = 0;
        tick(); tick();
        reset = 0;
        chk("rst_id_en", id_en, 0);
        chk("rst_id_op", id_op, NOP);
        chk("rst_hz_cnt", hz_cnt, 0);

        // Reset mid-stream with a valid instruction in flight.
        drive(30'h44, mk(ADD, 1, 2, 16'h2800), 1'b1);
        gpr_rd_data_0 = 32'h12; gpr_rd_data_1 = 32'h34;
        tick();
        chk("pre_rst_id_en", id_en, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("mid_rst_id_en", id_en, 0);
        chk("mid_rst_id_pc", id_pc, 0);
        chk("mid_rst_id_op", id_op, NOP);
        chk("mid_rst_dst", id_dst_addr, 0);
        chk("mid_rst_we", id_gpr_we, 0);
        chk("mid_rst_ld", id_mem_load, 0);
        chk("mid_rst_opr0", id_opr_0, 0);
        chk("mid_rst_opr1", id_opr_1, 0);
        chk("mid_rst_imm", id_imm, 0);
        chk("mid_rst_hz", hz_cnt, 0);

        tbl[0]  = '{30'h100, mk(BE, 1, 2, 16'hFFF0), 5, 5, 0, 0, 0, 0, 0, 0,
                    1, 30'h0F0, 5, 5, 32'hFFFFFFF0, BE, 0, 0, 0};
        tbl[1]  = '{30'h100, mk(BE, 1, 2, 16'hFFF0), 5, 6, 0, 0, 0, 0, 0, 0,
                    0, 30'h100, 5, 6, 32'hFFFFFFF0, BE, 0, 0, 0};
        tbl[2]  = '{30'h40, mk(ADD, 4, 4, 16'h2800), 1, 2, 1, 4, 32'hAA, 1, 4, 32'hBB,
                    0, 30'h40, 32'hAA, 32'hAA, 32'h2800, ADD, 1, 0, 5};
        tbl[3]  = '{30'h40, mk(ADD, 4, 4, 16'h2800), 1, 2, 0, 4, 32'hAA, 1, 4, 32'hBB,
                    0, 30'h40, 32'hBB, 32'hBB, 32'h2800, ADD, 1, 0, 5};
        tbl[4]  = '{30'h20, mk(BR, 7, 0, 16'h0), 32'h400, 32'h11, 0, 0, 0, 0, 0, 0,
                    1, 30'h100, 32'h400, 32'h11, 0, BR, 0, 0, 0};
        tbl[5]  = '{30'h3FFFFFFF, mk(BE, 1, 2, 16'h2), 7, 7, 0, 0, 0, 0, 0, 0,
                    1, 30'h1, 7, 7, 2, BE, 0, 0, 0};
        tbl[6]  = '{30'h50, mk(LDW, 1, 3, 16'h4), 32'h1000, 9, 0, 0, 0, 0, 0, 0,
                    0, 30'h50, 32'h1000, 9, 4, LDW, 1, 1, 3};
        tbl[7]  = '{30'h60, mk(6'h3f, 1, 2, 16'h1800), 3, 4, 0, 0, 0, 0, 0, 0,
                    0, 30'h60, 3, 4, 32'h1800, NOP, 0, 0, 0};
        tbl[8]  = '{30'h70, mk(SUB, 1, 2, 16'h1800), 32'h10, 32'h20, 1, 3, 32'hEE, 1, 2, 32'hCC,
                    0, 30'h70, 32'h10, 32'hCC, 32'h1800, SUB, 1, 0, 3};
        tbl[9]  = '{30'h80, mk(BNE, 1, 2, 16'h8000), 9, 9, 0, 0, 0, 0, 0, 0,
                    0, 30'h80, 9, 9, 32'hFFFF8000, BNE, 0, 0, 0};
        tbl[10] = '{30'h80, mk(BNE, 1, 2, 16'hFFFF), 1, 2, 0, 0, 0, 0, 0, 0,
                    1, 30'h7F, 1, 2, 32'hFFFFFFFF, BNE, 0, 0, 0};

        for (int i = 0; i < 11; i++) begin
            do_reset();
            drive(tbl[i].pc, tbl[i].insn, 1'b1);
            gpr_rd_data_0 = tbl[i].g0;     gpr_rd_data_1 = tbl[i].g1;
            ex_fwd_en     = tbl[i].ex_en;  ex_fwd_addr   = tbl[i].ex_a;  ex_fwd_data  = tbl[i].ex_d;
            mem_fwd_en    = tbl[i].mem_en; mem_fwd_addr  = tbl[i].mem_a; mem_fwd_data = tbl[i].mem_d;
            #1;
            chk($sformatf("v%0d_br_taken", i), ifid.br_taken, tbl[i].taken);
            chk($sformatf("v%0d_br_addr", i), ifid.br_addr, tbl[i].addr);
            chk($sformatf("v%0d_rd_addr0", i), gpr_rd_addr_0, tbl[i].insn[25:21]);
            tick();
            chk($sformatf("v%0d_id_en", i), id_en, 1);
            chk($sformatf("v%0d_opr0", i), id_opr_0, tbl[i].o0);
            chk($sformatf("v%0d_opr1", i), id_opr_1, tbl[i].o1);
            chk($sformatf("v%0d_imm", i), id_imm, tbl[i].imm);
            chk($sformatf("v%0d_op", i), id_op, tbl[i].op);
            chk($sformatf("v%0d_we", i), id_gpr_we, tbl[i].we);
            chk($sformatf("v%0d_ld", i), id_mem_load, tbl[i].ld);
            if (tbl[i].we) chk($sformatf("v%0d_dst", i), id_dst_addr, tbl[i].dst);
        end
        ex_fwd_en = 0; mem_fwd_en = 0;

        // Load-use: LDW r3 then ADD reading r3 as ra.
        do_reset();
        drive(30'h200, mk(LDW, 1, 3, 16'h4), 1'b1);
        tick();
        drive(30'h201, mk(ADD, 3, 2, 16'h2800), 1'b1);
        #1;
        chk("lu_hazard_on", ifid.ld_hazard, 1);
        tick();
        chk("lu_bubble_en", id_en, 0);
        chk("lu_bubble_we", id_gpr_we, 0);
        chk("lu_hz_cnt", hz_cnt, 1);
        chk("lu_hazard_off", ifid.ld_hazard, 0);
        tick();
        chk("lu_issue_en", id_en, 1);
        chk("lu_issue_op", id_op, ADD);
        chk("lu_issue_pc", id_pc, 30'h201);
        chk("lu_issue_dst", id_dst_addr, 5);

        // Stall three cycles with changing inputs.
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(30'($urandom), mk(LDW, 5'(i), 5'(i + 1), 16'($urandom)), 1'b1);
            gpr_rd_data_0 = $urandom;
            tick();
            chk($sformatf("stall%0d_pc", i), id_pc, 30'h201);
            chk($sformatf("stall%0d_op", i), id_op, ADD);
            chk($sformatf("stall%0d_en", i), id_en, 1);
            chk($sformatf("stall%0d_hz", i), hz_cnt, 1);
        end
        stall = 0;

        // Flush coinciding with a load-use hazard.
        drive(30'h300, mk(LDW, 1, 3, 16'h4), 1'b1);
        tick();
        drive(30'h301, mk(ADD, 3, 2, 16'h2800), 1'b1);
        flush = 1;
        #1;
        chk("fl_hazard_on", ifid.ld_hazard, 1);
        tick();
        flush = 0;
        chk("fl_id_en", id_en, 0);
        chk("fl_ld", id_mem_load, 0);
        chk("fl_hz_cnt", hz_cnt, 1);

        // Saturation: LDW r3 reading r3 hazards on every other cycle.
        do_reset();
        drive(30'h400, mk(LDW, 3, 3, 16'h0), 1'b1);
        n = 0;
        while (hz_cnt != 8'hFF && n < 2000) begin
            tick();
            n++;
        end
        chk("sat_reached_in_bound", n < 2000, 1);
        chk("sat_after_bubble_no_hz", ifid.ld_hazard, 0);
        tick();
        chk("sat_hazard_again", ifid.ld_hazard, 1);
        tick();
        chk("sat_hz_cnt", hz_cnt, 8'hFF);
        chk("sat_bubble_en", id_en, 0);

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            drive(30'($urandom),
                  {POOL[$urandom_range(0, 9)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 16'($urandom)},
                  $urandom_range(0, 3) != 0);
            gpr_rd_data_0 = $urandom_range(0, 3);
            gpr_rd_data_1 = $urandom_range(0, 3);
            ex_fwd_en     = 1'($urandom_range(0, 1));
            ex_fwd_addr   = 5'($urandom_range(0, 3));
            ex_fwd_data   = $urandom;
            mem_fwd_en    = 1'($urandom_range(0, 1));
            mem_fwd_addr  = 5'($urandom_range(0, 3));
            mem_fwd_data  = $urandom;
            #1;
            model_eval(e_t, e_a, e_h, e_o0, e_o1);
            chk("rnd_br_taken", ifid.br_taken, e_t);
            chk("rnd_br_addr", ifid.br_addr, e_a);
            chk("rnd_ld_hazard", ifid.ld_hazard, e_h);
            chk("rnd_rd_addr1", gpr_rd_addr_1, ifid.if_insn[20:16]);
            tick();
            model_update(e_h, e_o0, e_o1);
            chk("rnd_id_en", id_en, m_en);
            chk("rnd_we", id_gpr_we, m_we);
            chk("rnd_ld", id_mem_load, m_ld);
            chk("rnd_hz_cnt", hz_cnt, 8'(m_hz));
            if (m_en && m_fv) begin
                chk("rnd_pc", id_pc, m_pc);
                chk("rnd_op", id_op, m_op);
                chk("rnd_opr0", id_opr_0, m_o0);
                chk("rnd_opr1", id_opr_1, m_o1);
                chk("rnd_imm", id_imm, m_imm);
            end
            if (m_we) chk("rnd_dst", id_dst_addr, m_dst);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
